// File: rtl/exe_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : exe_issue_queue
// Function : Circular FIFO of {oper, argA, argB} commands feeding an execution
//            unit with registered outputs, stall, flush and drop reporting.
//            Optional macro ISSUE_BYPASS_EN: empty-queue commands issue in 1 edge.
// Revision : 1.0  initial release
// ============================================================================
module exe_issue_queue #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rsn,
  input  logic                       i_valid,
  input  logic [n-1:0]               i_oper,
  input  logic [m-1:0]               i_argA,
  input  logic [m-1:0]               i_argB,
  input  logic                       i_stall,
  input  logic                       i_flush,
  output logic                       o_ready,
  output logic [n-1:0]               o_oper,
  output logic [m-1:0]               o_argA,
  output logic [m-1:0]               o_argB,
  output logic                       o_issue,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop
);

  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam int c_ew = n + 2 * m;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;

  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic [c_ew-1:0] w_head;

  assign o_ready = (r_count < c_depth);
  assign o_count = r_count;

`ifdef ISSUE_BYPASS_EN
  // Empty queue and a free execution unit: hand the command straight over.
  assign w_bypass = (r_count == '0) & i_valid & ~i_stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = i_valid & o_ready & ~w_bypass & ~i_flush;
  assign w_pop  = (r_count != '0) & ~i_stall & ~i_flush;
  assign w_head = r_mem[r_rptr];

  // Entries carry no reset; they are only read once counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_oper, i_argA, i_argB};
    end
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      o_oper  <= '0;
      o_argA  <= '0;
      o_argB  <= '0;
      o_issue <= 1'b0;
      o_drop  <= 1'b0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      o_issue <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_drop  <= i_valid & ~o_ready;
      o_issue <= w_pop | w_bypass;
      if (w_bypass) begin
        o_oper <= i_oper;
        o_argA <= i_argA;
        o_argB <= i_argB;
      end else if (w_pop) begin
        {o_oper, o_argA, o_argB} <= w_head;
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_issue_queue
// Function : Directed self-checking bench for exe_issue_queue (m=4, n=2, DEPTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_exe_issue_queue;

`ifdef ISSUE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rsn = 1'b0;
  logic       i_valid = 1'b0;
  logic [1:0] i_oper = '0;
  logic [3:0] i_argA = '0;
  logic [3:0] i_argB = '0;
  logic       i_stall = 1'b0;
  logic       i_flush = 1'b0;
  logic       o_ready;
  logic [1:0] o_oper;
  logic [3:0] o_argA;
  logic [3:0] o_argB;
  logic       o_issue;
  logic [2:0] o_count;
  logic       o_drop;

  int r_tests = 0;
  int r_fails = 0;

  exe_issue_queue #(.m(4), .n(2), .DEPTH(4)) u_dut (
    .i_clk   (i_clk),
    .i_rsn   (i_rsn),
    .i_valid (i_valid),
    .i_oper  (i_oper),
    .i_argA  (i_argA),
    .i_argB  (i_argB),
    .i_stall (i_stall),
    .i_flush (i_flush),
    .o_ready (o_ready),
    .o_oper  (o_oper),
    .o_argA  (o_argA),
    .o_argB  (o_argB),
    .o_issue (o_issue),
    .o_count (o_count),
    .o_drop  (o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_tests++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxc;
    int j;
    // Reset state
    #12;
    check("rst_count", 32'(o_count), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_issue", 32'(o_issue), 0);
    check("rst_drop",  32'(o_drop), 0);
    check("rst_out",   32'({o_oper, o_argA, o_argB}), 0);
    #8 i_rsn = 1'b1;

    // First command: latency 2 edges (1 with bypass)
    i_valid = 1'b1; i_oper = 2'b10; i_argA = 4'b1001; i_argB = 4'b0011;
    step;
    check("s1_cnt_e1",   32'(o_count), c_byp ? 0 : 1);
    check("s1_issue_e1", 32'(o_issue), c_byp ? 1 : 0);
    i_valid = 1'b0;
    if (!c_byp) step;
    check("s1_issue", 32'(o_issue), 1);
    check("s1_oper",  32'(o_oper), 2);
    check("s1_argA",  32'(o_argA), 9);
    check("s1_argB",  32'(o_argB), 3);
    check("s1_cnt",   32'(o_count), 0);

    // Fill under stall, overflow drop, then drain in order
    i_stall = 1'b1; i_valid = 1'b1; i_oper = 2'b01; i_argB = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      i_argA = 4'(7 - i);
      step;
      if (i == 3) begin
        check("s2_cnt_full", 32'(o_count), 4);
        check("s2_ready_full", 32'(o_ready), 0);
      end
      if (i == 4) begin
        check("s2_drop", 32'(o_drop), 1);
        check("s2_cnt_drop", 32'(o_count), 4);
      end
    end
    i_valid = 1'b0; i_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      check("s2_issue", 32'(o_issue), 1);
      check("s2_argA", 32'(o_argA), 32'(7 - i));
      check("s2_cnt", 32'(o_count), 32'(3 - i));
      if (i == 0) check("s2_drop_clr", 32'(o_drop), 0);
    end
    step;
    check("s2_idle_issue", 32'(o_issue), 0);
    check("s2_hold_argA", 32'(o_argA), 4);

    // Full queue issues while a push is offered: push refused
    i_stall = 1'b1; i_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      i_argA = 4'(i);
      step;
    end
    i_stall = 1'b0; i_argA = 4'hf;
    step;
    check("s3_issue", 32'(o_issue), 1);
    check("s3_argA", 32'(o_argA), 1);
    check("s3_cnt", 32'(o_count), 3);
    check("s3_drop", 32'(o_drop), 1);
    i_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      step;
      check("s3_drain", 32'(o_argA), 32'(i));
    end
    step;
    check("s3_no_extra", 32'(o_issue), 0);
    check("s3_cnt_end", 32'(o_count), 0);

    // Flush with a simultaneous push
    i_stall = 1'b1; i_valid = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      i_argA = 4'(i);
      step;
    end
    check("s4_cnt3", 32'(o_count), 3);
    i_flush = 1'b1; i_stall = 1'b0; i_argA = 4'h8;
    step;
    check("s4_cnt", 32'(o_count), 0);
    check("s4_issue", 32'(o_issue), 0);
    check("s4_drop", 32'(o_drop), 0);
    check("s4_ready", 32'(o_ready), 1);
    i_flush = 1'b0; i_valid = 1'b0;
    step;
    check("s4_no_issue", 32'(o_issue), 0);
    check("s4_hold_argA", 32'(o_argA), 4);

    // Asynchronous reset between edges
    i_stall = 1'b1; i_valid = 1'b1;
    i_argA = 4'h8; step;
    i_argA = 4'h9; step;
    i_valid = 1'b0;
    check("s5_cnt2", 32'(o_count), 2);
    #2 i_rsn = 1'b0;
    #1;
    check("s5_cnt", 32'(o_count), 0);
    check("s5_ready", 32'(o_ready), 1);
    check("s5_issue", 32'(o_issue), 0);
    check("s5_drop", 32'(o_drop), 0);
    check("s5_out", 32'({o_oper, o_argA, o_argB}), 0);
    #1 i_rsn = 1'b1;
    i_stall = 1'b0; i_valid = 1'b1;
    i_oper = 2'b11; i_argA = 4'hA; i_argB = 4'h5;
    step;
    i_valid = 1'b0;
    check("s5_issue_e1", 32'(o_issue), c_byp ? 1 : 0);
    if (!c_byp) step;
    check("s5_first_issue", 32'(o_issue), 1);
    check("s5_first", 32'({o_oper, o_argA, o_argB}), 32'({2'b11, 4'hA, 4'h5}));
    step;
    check("s5_no_stale", 32'(o_issue), 0);

    // Streaming push/issue across pointer wrap
    maxc = 0;
    i_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i_oper = 2'(i); i_argA = 4'(i + 1); i_argB = ~4'(i);
      step;
      if (int'(o_count) > maxc) maxc = int'(o_count);
      j = c_byp ? i : i - 1;
      check("s6_issue", 32'(o_issue), (j >= 0) ? 1 : 0);
      if (j >= 0) check("s6_argA", 32'(o_argA), 32'(j + 1));
    end
    i_valid = 1'b0;
    step;
    check("s6_last_issue", 32'(o_issue), c_byp ? 0 : 1);
    check("s6_last_argA", 32'(o_argA), 9);
    check("s6_maxcnt", 32'(maxc), c_byp ? 0 : 1);

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_issue_queue.md
EXE_ISSUE_QUEUE -- requirements
Module: exe_issue_queue

Interface
REQ-001 The block SHALL have parameter m, default 4, operand width in bits.
REQ-002 The block SHALL have parameter n, default 2, operation-code width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, queue entries, a power of two, at least 2.
REQ-004 i_clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-005 i_rsn  input  1  reset, asynchronous, active-low.
REQ-006 i_valid  input  1  host offers a command this cycle.
REQ-007 i_oper  input  n  command operation code.
REQ-008 i_argA  input  m  command operand A, signed.
REQ-009 i_argB  input  m  command operand B, signed.
REQ-010 i_stall  input  1  downstream execution unit cannot accept a command this cycle.
REQ-011 i_flush  input  1  discard all queued commands.
REQ-012 o_ready  output  1  queue can accept a command this cycle.
REQ-013 o_oper  output  n  registered operation code to the execution unit.
REQ-014 o_argA  output  m  registered operand A to the execution unit.
REQ-015 o_argB  output  m  registered operand B to the execution unit.
REQ-016 o_issue  output  1  one-cycle strobe: o_oper/o_argA/o_argB hold a newly issued command.
REQ-017 o_count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-018 o_drop  output  1  one-cycle strobe: a command offered while o_ready was low was discarded.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries of {oper, argA, argB}, with write and read pointers wrapping from DEPTH-1 to 0.
REQ-020 o_ready SHALL be combinational: 1 when o_count < DEPTH, else 0.
REQ-021 Push: i_valid=1 and o_ready=1 at an edge SHALL store the command at the write pointer and advance it.
REQ-022 Drop: i_valid=1 and o_ready=0 at an edge SHALL leave the queue unchanged and set o_drop=1 for the following cycle.
REQ-023 Issue: o_count>0 and i_stall=0 at an edge SHALL load the head entry into o_oper/o_argA/o_argB, set o_issue=1, and advance the read pointer.
REQ-024 o_issue SHALL be 0 on every cycle without an issue, and o_oper/o_argA/o_argB SHALL hold their last values.
REQ-025 Simultaneous push and issue SHALL leave o_count unchanged; a full queue that issues does not accept a same-edge push, because o_ready was 0.
REQ-026 Latency through an empty queue without bypass SHALL be 2 edges: a command pushed at edge k issues at edge k+1 at the earliest.
REQ-027 Commands SHALL issue in strict push order, with no reordering or duplication.
REQ-028 i_flush=1 at an edge SHALL zero both pointers and o_count and force o_issue=0 and o_drop=0; any push or issue at that same edge SHALL be ignored.
REQ-029 i_stall=1 SHALL block issue only; pushes continue until full.

Reset
REQ-030 While i_rsn=0, pointers, o_count, o_oper, o_argA, o_argB, o_issue and o_drop SHALL be 0, with o_ready=1, and stored entries SHALL be don't-care.
REQ-031 Reset asserted mid-operation SHALL take effect immediately, without waiting for i_clk, and all queued commands SHALL be lost.
REQ-032 The first push SHALL be accepted at the first rising edge after i_rsn rises.

Configuration
REQ-033 Macro ISSUE_BYPASS_EN, when defined, SHALL enable bypass: at an edge with o_count=0, i_valid=1, i_stall=0 and i_flush=0, the incoming command SHALL load o_oper/o_argA/o_argB directly with o_issue=1, the FIFO SHALL not be written, and latency SHALL be 1 edge.
REQ-034 Without ISSUE_BYPASS_EN, every command SHALL pass through FIFO storage as in REQ-026.

Verification (m=4, n=2, DEPTH=4)
REQ-035 Reset, then push {10,1001,0011} at edge 1 with i_stall=0 -> o_issue=1 with o_oper=10, o_argA=1001, o_argB=0011 after edge 2, or after edge 1 with ISSUE_BYPASS_EN.
REQ-036 i_stall=1, push argA=0111,0110,0101,0100,0011 on consecutive edges -> o_count=4 and o_ready=0 after the fourth push, o_drop=1 after the fifth; release stall -> argA issues 0111,0110,0101,0100 on 4 consecutive edges.
REQ-037 Queue full with i_stall=0 and i_valid=1 -> the issue occurs, the push is not accepted, and o_count=3.
REQ-038 Three entries queued, then i_flush=1 together with i_valid=1 -> o_count=0, o_issue=0, and no issue on the next edge.
REQ-039 Pulse i_rsn=0 between clock edges with 2 entries queued -> all outputs 0 and o_ready=1 immediately; the next push issues as the first command.
REQ-040 Run 9 push/issue pairs with i_stall=0 -> correct order across pointer wrap, and o_count never exceeds 1 (0 with bypass).
